// File: rtl/two_phase_gen_pkg.sv
// Shared clock-control definitions: FSM state codes, phase-timer width and
// a helper that checks interval parameters at elaboration.
package two_phase_gen_pkg;

   // Width of the phase/gap down-counter; intervals are 1..15 clk cycles.
   localparam int TMR_W = 4;

   typedef logic [TMR_W-1:0] tmr_t;

   // Two-phase generator state encoding (3-bit, kept stable for older users).
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PH1  = 3'd1;
   localparam logic [2:0] ST_GAP1 = 3'd2;
   localparam logic [2:0] ST_PH2  = 3'd3;
   localparam logic [2:0] ST_GAP2 = 3'd4;

   // True when an interval length fits the 4-bit timer and is non-zero.
   function automatic bit interval_ok(input int len);
      return (len >= 1) && (len <= 15);
   endfunction

endpackage

// File: rtl/two_phase_gen_timer.sv
// Loadable 4-bit down-counter with a zero flag. Times both the phase-high
// and the non-overlap gap intervals; holds at zero until reloaded.
module phase_timer
   import two_phase_gen_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  tmr_t load_val,
   output tmr_t cnt,
   output logic zero
);

   tmr_t cnt_reg;

   // Load takes priority; otherwise count down and stop at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - tmr_t'(1);
      end
   end

   assign cnt  = cnt_reg;
   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/two_phase_gen.sv
// Non-overlapping two-phase clock generator. A five-state FSM walks
// PH1 -> GAP1 -> PH2 -> GAP2, timing each state with phase_timer. All
// outputs are registered from the next-state decode so they change on
// the same edge as the state itself.
module two_phase_gen
   import two_phase_gen_pkg::*;
#(
   parameter int PH_W  = 2,
   parameter int GAP   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   output logic             c1,
   output logic             c2,
   output logic             busy,
   output logic             cycle_done,
   output logic [CNT_W-1:0] cyc_cnt
);

   // Interval lengths must fit the timer; reject bad builds outright.
   if (!interval_ok(PH_W) || !interval_ok(GAP)) begin : g_param_check
      $error("two_phase_gen: PH_W and GAP must be in 1..15");
   end

   localparam tmr_t PH_LOAD  = tmr_t'(PH_W - 1);
   localparam tmr_t GAP_LOAD = tmr_t'(GAP - 1);

   logic [2:0]       state_reg, state_next;
   logic             step_flag_reg, step_flag_next;
   logic             c1_reg, c2_reg, busy_reg, cycle_done_reg;
   logic             cycle_done_next;
   logic [CNT_W-1:0] cyc_cnt_reg;

   logic             tmr_load;
   tmr_t             tmr_load_val;
   tmr_t             tmr_cnt;
   logic             tmr_zero;
   logic             step_pending;
   logic             cycle_end;

   phase_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .cnt      (tmr_cnt),
      .zero     (tmr_zero)
   );

   // A live run request always overrides a pending single step, so a step
   // cycle turns into free-run if run is high at the GAP2 decision.
   assign step_pending = step_flag_reg & ~run;
   assign cycle_end    = (state_reg == ST_GAP2) && tmr_zero;

   // Next-state decode; the timer is reloaded on every state entry.
   always_comb begin
      state_next     = state_reg;
      step_flag_next = step_flag_reg;
      tmr_load       = 1'b0;
      tmr_load_val   = PH_LOAD;
      if (run) begin
         step_flag_next = 1'b0;
      end
      case (state_reg)
         ST_IDLE: begin
            if (run) begin
               state_next = ST_PH1;
               tmr_load   = 1'b1;
            end else if (step) begin
               state_next     = ST_PH1;
               tmr_load       = 1'b1;
               step_flag_next = 1'b1;
            end
         end
         ST_PH1: begin
            if (tmr_zero) begin
               state_next   = ST_GAP1;
               tmr_load     = 1'b1;
               tmr_load_val = GAP_LOAD;
            end
         end
         ST_GAP1: begin
            if (tmr_zero) begin
               state_next = ST_PH2;
               tmr_load   = 1'b1;
            end
         end
         ST_PH2: begin
            if (tmr_zero) begin
               state_next   = ST_GAP2;
               tmr_load     = 1'b1;
               tmr_load_val = GAP_LOAD;
            end
         end
         ST_GAP2: begin
            if (tmr_zero) begin
               if (run && !step_pending) begin
                  state_next = ST_PH1;
                  tmr_load   = 1'b1;
               end else begin
                  state_next     = ST_IDLE;
                  step_flag_next = 1'b0;
               end
            end
         end
         default: begin
            state_next     = ST_IDLE;
            step_flag_next = 1'b0;
         end
      endcase
   end

   // cycle_done marks the final GAP2 cycle: predict whether the timer will
   // read zero in the state being entered (fresh load or last decrement).
   always_comb begin
      cycle_done_next = 1'b0;
      if (state_next == ST_GAP2) begin
         cycle_done_next = tmr_load ? (tmr_load_val == '0)
                                    : (tmr_cnt == tmr_t'(1));
      end
   end

   // State, flag and Moore outputs all registered on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         step_flag_reg  <= 1'b0;
         c1_reg         <= 1'b0;
         c2_reg         <= 1'b0;
         busy_reg       <= 1'b0;
         cycle_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         step_flag_reg  <= step_flag_next;
         c1_reg         <= (state_next == ST_PH1);
         c2_reg         <= (state_next == ST_PH2);
         busy_reg       <= (state_next != ST_IDLE);
         cycle_done_reg <= cycle_done_next;
      end
   end

   // Completed-cycle counter; bumps on the edge leaving GAP2 and wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_cnt_reg <= '0;
      end else if (cycle_end) begin
         cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
      end
   end

   assign c1         = c1_reg;
   assign c2         = c2_reg;
   assign busy       = busy_reg;
   assign cycle_done = cycle_done_reg;
   assign cyc_cnt    = cyc_cnt_reg;

endmodule

// File: tb/tb_two_phase_gen.sv
// Self-checking bench for two_phase_gen (PH_W=2, GAP=1, CNT_W=8).
// A position-in-period reference model pushes expected outputs into a
// scoreboard queue before each edge; they are popped and compared 1 ns
// after the edge.
module tb_two_phase_gen;

   localparam int PH_W   = 2;
   localparam int GAP    = 1;
   localparam int CNT_W  = 8;
   localparam int PERIOD = 2 * (PH_W + GAP);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             run = 1'b0;
   logic             step = 1'b0;
   logic             c1, c2, busy, cycle_done;
   logic [CNT_W-1:0] cyc_cnt;

   two_phase_gen #(.PH_W(PH_W), .GAP(GAP), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .step       (step),
      .c1         (c1),
      .c2         (c2),
      .busy       (busy),
      .cycle_done (cycle_done),
      .cyc_cnt    (cyc_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             c1;
      logic             c2;
      logic             busy;
      logic             cd;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: active flag, position inside the period, cycle count.
   bit               m_active = 1'b0;
   int               m_pos    = 0;
   logic [CNT_W-1:0] m_cnt    = '0;

   // Per-scenario activity counters.
   int busy_seen = 0;
   int cd_seen   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the model using the inputs about to be sampled; push result.
   task automatic model_step();
      exp_t e;
      if (!rst_n) begin
         m_active = 1'b0;
         m_pos    = 0;
         m_cnt    = '0;
      end else if (!m_active) begin
         if (run || step) begin
            m_active = 1'b1;
            m_pos    = 0;
         end
      end else if (m_pos == PERIOD - 1) begin
         m_cnt = m_cnt + 1'b1;
         if (run) m_pos = 0;
         else     m_active = 1'b0;
      end else begin
         m_pos++;
      end
      e.busy = m_active;
      e.c1   = m_active && (m_pos < PH_W);
      e.c2   = m_active && (m_pos >= PH_W + GAP) && (m_pos < 2 * PH_W + GAP);
      e.cd   = m_active && (m_pos == PERIOD - 1);
      e.cnt  = m_cnt;
      sb_q.push_back(e);
   endtask

   // One clock: predict, let the edge happen, pop and compare.
   task automatic tick();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      check("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("c1", c1, e.c1);
         check("c2", c2, e.c2);
         check("busy", busy, e.busy);
         check("cycle_done", cycle_done, e.cd);
         check("cyc_cnt", cyc_cnt, e.cnt);
      end
      check("no_overlap", c1 & c2, 0);
      if (busy) busy_seen++;
      if (cycle_done) cd_seen++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run   = 1'b0;
      step  = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Bounded wait for the generator to return to IDLE.
   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      // Reset state
      do_reset();
      tick();
      check("reset_c1", c1, 0);
      check("reset_busy", busy, 0);
      check("reset_cnt", cyc_cnt, 0);
      $display("[TB] reset: busy=%0d cyc_cnt=%0d", busy, cyc_cnt);

      // Free-run: cycles 1..18
      run = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 1) check("fr_c1_first", c1, 1);
         if (k == 6) check("fr_cd_cycle6", cycle_done, 1);
         if (k == 7) check("fr_cnt_after6", cyc_cnt, 1);
      end
      tick();
      check("fr_cnt_after18", cyc_cnt, 3);
      run = 1'b0;
      wait_idle(20);
      $display("[TB] free-run: cyc_cnt=%0d", cyc_cnt);

      // Single step from IDLE
      do_reset();
      busy_seen = 0;
      cd_seen   = 0;
      step = 1'b1;
      tick();
      step = 1'b0;
      ticks(9);
      check("step_busy_cycles", busy_seen, 6);
      check("step_cd_pulses", cd_seen, 1);
      check("step_cnt", cyc_cnt, 1);
      $display("[TB] single-step: busy_cycles=%0d cyc_cnt=%0d", busy_seen, cyc_cnt);

      // run dropped in PH1 of the second cycle
      do_reset();
      run = 1'b1;
      ticks(7);
      check("drop_in_ph1", c1, 1);
      run = 1'b0;
      ticks(10);
      check("drop_cnt", cyc_cnt, 2);
      check("drop_idle", busy, 0);
      $display("[TB] run-drop: cyc_cnt=%0d", cyc_cnt);

      // step during PH2 of a free-run cycle, then run dropped
      do_reset();
      run = 1'b1;
      ticks(4);
      check("step_in_ph2", c2, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      run  = 1'b0;
      busy_seen = 0;
      ticks(12);
      check("busy_step_ignored", busy_seen, 1);
      check("busy_step_cnt", cyc_cnt, 1);
      $display("[TB] step-while-busy: cyc_cnt=%0d", cyc_cnt);

      // Counter wrap: 256 full cycles
      do_reset();
      run = 1'b1;
      ticks(256 * PERIOD - 1);
      check("wrap_pre_cnt", cyc_cnt, 255);
      run = 1'b0;
      cd_seen = 0;
      ticks(2);
      check("wrap_cd_once", cd_seen, 1);
      check("wrap_cnt", cyc_cnt, 0);
      check("wrap_idle", busy, 0);
      $display("[TB] wrap: cyc_cnt=%0d", cyc_cnt);

      // Reset mid-PH2, then release with run held
      do_reset();
      run = 1'b1;
      ticks(4);
      check("midrst_in_ph2", c2, 1);
      rst_n = 1'b0;
      tick();
      check("midrst_c2", c2, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cnt", cyc_cnt, 0);
      rst_n = 1'b1;
      tick();
      check("midrst_c1_rise", c1, 1);
      run = 1'b0;
      wait_idle(20);
      $display("[TB] mid-reset: cyc_cnt=%0d", cyc_cnt);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
